hi_lo_divider: RTL and testbench

Iterative restoring divider for DIV/DIVU in the MIPS CPU datapath. It accepts a start pulse with two 32-bit operands from the register file. After a fixed latency it presents the quotient (for LO) and remainder (for HI) with a one-cycle `done` pulse. The HI/LO control block captures those values on `done`, and the pipeline stalls on `busy`.

---
 rtl/hi_lo_divider.sv | 148 ++++++++++++++
 tb/tb_hi_lo_divider.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hi_lo_divider.sv
// Iterative restoring divider for DIV/DIVU; quotient to LO, remainder to HI.
// Optional macro HILO_DIV_EARLY_OUT_EN skips iteration when the quotient is trivially 0.
module hi_lo_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]       rem_q, rem_d;
   logic [WIDTH-1:0]       quo_q, quo_d;
   logic [WIDTH-1:0]       dvs_q, dvs_d;
   logic [WIDTH-1:0]       orig_q, orig_d;
   logic                   sgn_q, sgn_d;
   logic                   negq_q, negq_d;
   logic                   negr_q, negr_d;
   logic                   dbz_q, dbz_d;
   logic [WIDTH-1:0]       lo_q, lo_d;
   logic [WIDTH-1:0]       hi_q, hi_d;
   logic                   dbzo_q, dbzo_d;
   logic [WIDTH:0]         shifted;
   logic signed [WIDTH:0]  trial;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
      cond_neg = n ? -v : v;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      orig_d  = orig_q;
      sgn_d   = sgn_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dbz_d   = dbz_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dbzo_d  = dbzo_q;
      // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = $signed(shifted - {1'b0, dvs_q});

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_PREP;
               quo_d   = dividend;
               dvs_d   = divisor;
               orig_d  = dividend;
               sgn_d   = is_signed;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PREP: begin
            quo_d   = cond_neg(quo_q, sgn_q & quo_q[WIDTH-1]);
            dvs_d   = cond_neg(dvs_q, sgn_q & dvs_q[WIDTH-1]);
            negq_d  = sgn_q & (quo_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
            negr_d  = sgn_q & quo_q[WIDTH-1];
            dbz_d   = (dvs_q == '0);
            rem_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_ITER;
`ifdef HILO_DIV_EARLY_OUT_EN
            if ((dvs_q == '0) || (quo_d < dvs_d)) begin
               rem_d   = quo_d;
               quo_d   = '0;
               state_d = S_FIX;
            end
`endif
         end
         S_ITER: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_FIX: begin
            lo_d    = dbz_q ? '1     : cond_neg(quo_q, negq_q);
            hi_d    = dbz_q ? orig_q : cond_neg(rem_q, negr_q);
            dbzo_d  = dbz_q;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && (state_q inside {S_PREP, S_ITER, S_FIX})) begin
         state_d = S_IDLE;
         lo_d    = lo_q;
         hi_d    = hi_q;
         dbzo_d  = dbzo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         lo_q    <= '0;
         hi_q    <= '0;
         dbzo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         dbzo_q  <= dbzo_d;
      end
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      orig_q <= orig_d;
      sgn_q  <= sgn_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dbz_q  <= dbz_d;
   end

   assign busy        = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
   assign done        = (state_q == S_DONE);
   assign result_lo   = lo_q;
   assign result_hi   = hi_q;
   assign div_by_zero = dbzo_q;

endmodule

// File: tb/tb_hi_lo_divider.sv
// Scoreboard bench for hi_lo_divider: random and directed DIV/DIVU against an arithmetic model.
module tb_hi_lo_divider;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          is_signed = 1'b0;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          abort = 1'b0;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  result_lo, result_hi;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         dbz;
      int           cyc;
   } exp_t;

   exp_t sbq[$];

   hi_lo_divider #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor), .abort(abort),
      .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic longint mag(input logic s, input logic [W-1:0] v);
      if (s && v[W-1]) return -longint'($signed(v));
      return longint'(v);
   endfunction

   // Reference: plain arithmetic on 64-bit magnitudes, signs applied afterwards.
   function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint ma, mb, q, r;
      e.cyc = 0;
      if (b == '0) begin
         e.lo = '1; e.hi = a; e.dbz = 1'b1;
      end else begin
         ma = mag(s, a);
         mb = mag(s, b);
         q  = ma / mb;
         r  = ma % mb;
         if (s && (a[W-1] ^ b[W-1])) q = -q;
         if (s && a[W-1])            r = -r;
         e.lo = q[W-1:0]; e.hi = r[W-1:0]; e.dbz = 1'b0;
      end
      return e;
   endfunction

   function automatic int latency(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef HILO_DIV_EARLY_OUT_EN
      if ((b == '0) || (mag(s, a) < mag(s, b))) return 2;
`endif
      return W + 2;
   endfunction

   // Called at a negedge; start is sampled on the following posedge (E0).
   task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_done);
      exp_t e;
      start = 1'b1; is_signed = s; dividend = a; divisor = b;
      if (expect_done) begin
         e = model(s, a, b);
         e.cyc = cyc + 1 + latency(s, a, b);
         sbq.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100; i++) begin
         if (done) return;
         @(negedge clk);
      end
      checks++; failures++;
      $display("FAIL wait_done timeout at cycle %0d", cyc);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain pending=%0d required=0", sbq.size());
      end
   endtask

   initial begin
      fork
         begin : monitor
            exp_t e;
            forever begin
               @(negedge clk);
               if (done) begin
                  if (sbq.size() == 0) begin
                     checks++; failures++;
                     $display("FAIL unexpected_done lo=%h hi=%h required=no_done", result_lo, result_hi);
                  end else begin
                     e = sbq.pop_front();
                     check("result_lo", result_lo, e.lo);
                     check("result_hi", result_hi, e.hi);
                     check("div_by_zero", W'(div_by_zero), W'(e.dbz));
                     check("done_cycle", W'(cyc), W'(e.cyc));
                     check("busy_in_done", W'(busy), '0);
                  end
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      check("rst_busy", W'(busy), '0);
      check("rst_done", W'(done), '0);
      check("rst_lo", result_lo, '0);
      check("rst_hi", result_hi, '0);
      check("rst_dbz", W'(div_by_zero), '0);
      reset = 1'b1;
      @(negedge clk);

      // Directed cases
      issue(1'b0, 32'd100, 32'd7, 1'b1);
      for (int i = 0; i < W + 1; i++) begin
         check("busy_in_flight", W'(busy), 32'd1);
         @(negedge clk);
      end
      wait_done(); @(negedge clk);
      issue(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1); wait_done(); @(negedge clk);
      issue(1'b0, 32'hFFFFFFF9, 32'd2, 1'b1); wait_done(); @(negedge clk);
      issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1); wait_done(); @(negedge clk);
      issue(1'b0, 32'd5, 32'd0, 1'b1); wait_done(); @(negedge clk);
      issue(1'b1, 32'hFFFFFFF6, 32'd0, 1'b1); wait_done(); @(negedge clk);
      issue(1'b0, 32'd3, 32'd10, 1'b1); wait_done(); @(negedge clk);
      issue(1'b1, 32'hFFFFFFFD, 32'd10, 1'b1); wait_done(); @(negedge clk);

      // Start during an operation is ignored; start in DONE runs back-to-back
      issue(1'b0, 32'd100, 32'd7, 1'b1);
      repeat (3) @(negedge clk);
      start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      issue(1'b0, 32'd9, 32'd3, 1'b1);
      wait_done(); @(negedge clk);
      wait_empty();

      // Reset mid-operation
      issue(1'b0, 32'd100, 32'd7, 1'b0);
      repeat (8) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("midrst_busy", W'(busy), '0);
      check("midrst_lo", result_lo, '0);
      check("midrst_hi", result_hi, '0);
      repeat (45) @(negedge clk);

      // Abort mid-operation keeps prior results
      issue(1'b0, 32'd1000, 32'd3, 1'b1); wait_done(); @(negedge clk);
      issue(1'b0, 32'd100, 32'd7, 1'b0);
      repeat (8) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", W'(busy), '0);
      check("abort_lo", result_lo, 32'd333);
      check("abort_hi", result_hi, 32'd1);
      repeat (45) @(negedge clk);

      // Randomized operations, some back-to-back
      for (int n = 0; n < 60; n++) begin
         logic [W-1:0] a, b;
         logic         s;
         a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: b = '0;
            1: b = $urandom_range(1, 15);
            2: begin a = 32'h80000000; b = '1; end
            3: a = $urandom_range(0, 50);
            default: ;
         endcase
         issue(s, a, b, 1'b1);
         wait_done();
         if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      @(negedge clk);
      wait_empty();
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
